// File: rtl/multicycle_core.sv
// Multi-cycle 16-bit-instruction core: one FSM walks fetch/decode/execute/memory/writeback,
// with instruction and data memories behind req/ack handshakes that may stall indefinitely.
module multicycle_core #(
  parameter int          DATA_W   = 16,
  parameter int          PC_W     = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ready,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [7:0]        dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic [PC_W-1:0]   pc,
  output logic              retire,
  output logic              halted,
  output logic              illegal,
  input  logic [2:0]        dbg_sel,
  output logic [DATA_W-1:0] dbg_data
);

  // state   | meaning
  // IDLE    | paused at an instruction boundary, waiting for ready
  // FETCH   | imem_req high until imem_ack, instruction latched on ack
  // DECODE  | one cycle for operand selection
  // EXEC    | ALU/LI result captured, branches resolved, mem address latched
  // MEM     | dmem_req high until dmem_ack
  // WB      | register write, pc advance, retire
  // HALT    | terminal, left only by reset
  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_LI   = 4'h5;
  localparam logic [3:0] OP_LD   = 4'h6;
  localparam logic [3:0] OP_ST   = 4'h7;
  localparam logic [3:0] OP_BEQZ = 4'h8;
  localparam logic [3:0] OP_JR   = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t state, state_nxt;

  logic [15:0]       ir;
  logic [PC_W-1:0]   pc_q;
  logic [DATA_W-1:0] regs [8];
  logic [DATA_W-1:0] result;
  logic [7:0]        dmem_addr_q;
  logic [DATA_W-1:0] dmem_wdata_q;
  logic              illegal_q;

  logic [3:0]        op;
  logic [2:0]        rd, rs, rt;
  logic [7:0]        imm8;
  logic signed [7:0] imm_s;
  logic [PC_W-1:0]   pc_inc, pc_br;
  logic [DATA_W-1:0] imm_ext, alu;
  logic              is_wb_op, is_mem_op, is_illegal;
  state_t            boundary;

  assign op    = ir[15:12];
  assign rd    = ir[11:9];
  assign rs    = ir[8:6];
  assign rt    = ir[5:3];
  assign imm8  = ir[7:0];
  assign imm_s = imm8;

  assign imm_ext    = DATA_W'(imm_s);
  assign pc_inc     = pc_q + PC_W'(1);
  assign pc_br      = pc_inc + PC_W'(imm_s);
  assign is_wb_op   = (op >= OP_ADD) && (op <= OP_LI);
  assign is_mem_op  = (op == OP_LD) || (op == OP_ST);
  assign is_illegal = (op >= 4'hA) && (op <= 4'hE);
  // ready only matters where one instruction has fully completed
  assign boundary   = ready ? S_FETCH : S_IDLE;

  always_comb begin
    alu = '0;
    case (op)
      OP_ADD:  alu = regs[rs] + regs[rt];
      OP_SUB:  alu = regs[rs] - regs[rt];
      OP_AND:  alu = regs[rs] & regs[rt];
      OP_OR:   alu = regs[rs] | regs[rt];
      OP_LI:   alu = imm_ext;
      default: alu = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (ready) state_nxt = S_FETCH;
      S_FETCH:  if (imem_ack) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        if (is_mem_op)           state_nxt = S_MEM;
        else if (is_wb_op)       state_nxt = S_WB;
        else if (op == OP_HALT)  state_nxt = S_HALT;
        else                     state_nxt = boundary;
      end
      S_MEM:    if (dmem_ack) state_nxt = (op == OP_ST) ? boundary : S_WB;
      S_WB:     state_nxt = boundary;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    retire   = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH: imem_req = 1'b1;
      S_EXEC:  retire = !(is_mem_op || is_wb_op);
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op == OP_ST);
        retire   = dmem_ack && (op == OP_ST);
      end
      S_WB:    retire = 1'b1;
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ir           <= '0;
      pc_q         <= PC_W'(RESET_PC);
      result       <= '0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      illegal_q    <= 1'b0;
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else begin
      if (state == S_FETCH && imem_ack) ir <= imem_rdata;
      if (state == S_EXEC) begin
        if (is_wb_op) begin
          result <= alu;
        end else if (is_mem_op) begin
          dmem_addr_q  <= imm8;
          dmem_wdata_q <= regs[rd];
        end else if (op == OP_BEQZ) begin
          pc_q <= (regs[rd] == '0) ? pc_br : pc_inc;
        end else if (op == OP_JR) begin
          pc_q <= pc_br;
        end else if (op != OP_HALT) begin
          // NOP and undefined opcodes just step the pc
          pc_q <= pc_inc;
          if (is_illegal) illegal_q <= 1'b1;
        end
      end
      if (state == S_MEM && dmem_ack) begin
        if (op == OP_LD) result <= dmem_rdata;
        else             pc_q   <= pc_inc;
      end
      if (state == S_WB) begin
        regs[rd] <= result;
        pc_q     <= pc_inc;
      end
    end
  end

  assign pc         = pc_q;
  assign imem_addr  = pc_q;
  assign dmem_addr  = dmem_addr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign illegal    = illegal_q;
  assign dbg_data   = regs[dbg_sel];

endmodule

// File: tb/tb_multicycle_core.sv
// Directed bench for multicycle_core: behavioural memories with per-address fetch
// wait states, a handshake/latency monitor, and hand-computed expected values.
module tb_multicycle_core;
  localparam int DATA_W = 16;
  localparam int PC_W   = 8;

  logic              clk = 1'b0, rst_n = 1'b0, ready = 1'b0;
  logic              imem_req, imem_ack;
  logic [PC_W-1:0]   imem_addr, pc;
  logic [15:0]       imem_rdata;
  logic              dmem_req, dmem_we, dmem_ack;
  logic [7:0]        dmem_addr;
  logic [DATA_W-1:0] dmem_wdata, dmem_rdata, dbg_data;
  logic              retire, halted, illegal;
  logic [2:0]        dbg_sel = 3'd0;

  always #5 clk = ~clk;

  multicycle_core #(.DATA_W(DATA_W), .PC_W(PC_W), .RESET_PC(0)) dut (
    .clk(clk), .rst_n(rst_n), .ready(ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc(pc), .retire(retire), .halted(halted), .illegal(illegal),
    .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  logic [15:0]       imem [256];
  int                iwait [256];
  int                dwait = 0;
  logic [DATA_W-1:0] ld_data = '0;
  int                n_checks = 0, n_pass = 0;
  int                st_cnt = 0;
  logic [7:0]        st_addr = '0, ld_addr = '0;
  logic [DATA_W-1:0] st_data = '0;
  int                n_retire = 0, cyc = 0, t0 = 0, hs_viol = 0, halt_req = 0;
  bit                busy = 0;
  int                lat [16];
  logic              p_ireq = 0, p_iack = 0, p_dreq = 0, p_dack = 0, p_dwe = 0;
  logic [PC_W-1:0]   p_iaddr = '0;
  logic [7:0]        p_daddr = '0;
  logic [DATA_W-1:0] p_dwdata = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic chk_reg(input string tag, input int r, input logic [63:0] exp);
    dbg_sel = 3'(r);
    #1;
    chk(tag, 64'(dbg_data), exp);
  endtask

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd, rs, rt);
    return {op, rd, rs, rt, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd, input logic [7:0] imm);
    return {op, rd, 1'b0, imm};
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      imem[i]  = 16'hF000;
      iwait[i] = 0;
    end
    dwait = 0;
  endtask

  task automatic do_reset(input logic rdy);
    rst_n = 1'b0;
    ready = rdy;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_ret(input int n);
    int k = 0;
    while (n_retire < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("retire_wait", 64'(n_retire >= n), 64'd1);
  endtask

  task automatic wait_halt();
    int k = 0;
    while (!halted && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("halt_wait", 64'(halted), 64'd1);
  endtask

  // memory responders, driven away from the active edge
  initial begin
    int icnt = 0, dcnt = 0;
    imem_ack = 1'b0; dmem_ack = 1'b0; imem_rdata = '0; dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) st_cnt = 0;
      imem_rdata = imem[imem_addr];
      if (imem_req) begin
        imem_ack = (icnt >= iwait[imem_addr]);
        icnt++;
      end else begin
        imem_ack = 1'b0;
        icnt = 0;
      end
      dmem_rdata = ld_data;
      if (dmem_req) begin
        dmem_ack = (dcnt >= dwait);
        dcnt++;
        if (dmem_ack && dmem_we) begin
          st_cnt++; st_addr = dmem_addr; st_data = dmem_wdata;
        end
        if (dmem_ack && !dmem_we) ld_addr = dmem_addr;
      end else begin
        dmem_ack = 1'b0;
        dcnt = 0;
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      n_retire = 0; busy = 0; p_ireq = 0; p_dreq = 0;
    end else begin
      cyc++;
      if (p_ireq && !p_iack && (!imem_req || imem_addr != p_iaddr)) hs_viol++;
      if (p_dreq && !p_dack && (!dmem_req || dmem_addr != p_daddr || dmem_we != p_dwe ||
                                dmem_wdata != p_dwdata)) hs_viol++;
      if (retire && ((imem_req && !imem_ack) || (dmem_req && !dmem_ack))) hs_viol++;
      if (halted && (imem_req || dmem_req)) halt_req++;
      if (imem_req && !busy) begin busy = 1; t0 = cyc; end
      if (retire) begin
        lat[n_retire % 16] = cyc - t0 + 1;
        n_retire++;
        busy = 0;
      end
      p_ireq = imem_req; p_iack = imem_ack; p_iaddr = imem_addr;
      p_dreq = dmem_req; p_dack = dmem_ack; p_daddr = dmem_addr;
      p_dwe = dmem_we; p_dwdata = dmem_wdata;
    end
  end

  initial begin
    int k;
    for (int i = 0; i < 16; i++) lat[i] = 0;

    // zero-wait program: LI r1,5; LI r2,0xFD; ADD r3,r1,r2; ST r3,0x10; HALT
    clear_mem();
    imem[0] = enc_i(4'h5, 3'd1, 8'h05);
    imem[1] = enc_i(4'h5, 3'd2, 8'hFD);
    imem[2] = enc_r(4'h1, 3'd3, 3'd1, 3'd2);
    imem[3] = enc_i(4'h7, 3'd3, 8'h10);
    imem[4] = 16'hF000;
    do_reset(1'b1);
    wait_halt();
    chk("prog_retires", 64'(n_retire), 64'd5);
    chk_reg("prog_r2", 2, 64'hFFFD);
    chk_reg("prog_r3", 3, 64'h0002);
    chk("prog_st_cnt", 64'(st_cnt), 64'd1);
    chk("prog_st_addr", 64'(st_addr), 64'h10);
    chk("prog_st_data", 64'(st_data), 64'h2);
    chk("lat_li", 64'(lat[0]), 64'd4);
    chk("lat_add", 64'(lat[2]), 64'd4);
    chk("lat_st", 64'(lat[3]), 64'd4);
    chk("lat_halt", 64'(lat[4]), 64'd3);
    repeat (20) @(negedge clk);
    chk("halt_no_req", 64'(halt_req), 64'd0);
    chk("halt_no_retire", 64'(n_retire), 64'd5);
    chk("halt_sticky", 64'(halted), 64'd1);
    // asynchronous reset while halted clears everything without an edge
    #2 rst_n = 1'b0;
    #1;
    chk("rst_halted", 64'(halted), 64'd0);
    chk("rst_dmem_addr", 64'(dmem_addr), 64'd0);
    chk("rst_dmem_wdata", 64'(dmem_wdata), 64'd0);
    chk("rst_pc_async", 64'(pc), 64'd0);
    chk_reg("rst_r3", 3, 64'd0);

    // stalled fetch (3 cycles) and stalled load (2 cycles)
    clear_mem();
    imem[0] = enc_i(4'h6, 3'd4, 8'h20);
    imem[1] = 16'hF000;
    iwait[0] = 3; iwait[1] = 3;
    dwait = 2;
    ld_data = 16'h1234;
    do_reset(1'b1);
    wait_halt();
    chk_reg("ld_r4", 4, 64'h1234);
    chk("ld_addr", 64'(ld_addr), 64'h20);
    chk("lat_ld_stall", 64'(lat[0]), 64'd10);
    chk("stall_retires", 64'(n_retire), 64'd2);
    chk("stall_handshake", 64'(hs_viol), 64'd0);

    // branches and pc wrap
    clear_mem();
    imem[8'h00] = enc_i(4'h9, 3'd0, 8'h0F);
    imem[8'h10] = enc_i(4'h8, 3'd0, 8'h03);
    imem[8'h14] = enc_i(4'h5, 3'd1, 8'h05);
    imem[8'h15] = enc_i(4'h8, 3'd1, 8'h03);
    imem[8'h16] = enc_i(4'h9, 3'd0, 8'hE8);
    imem[8'hFF] = 16'h0000;
    do_reset(1'b1);
    wait_ret(1); chk("jr_to_10", 64'(pc), 64'h10);
    wait_ret(2); chk("beqz_taken", 64'(pc), 64'h14);
    chk("lat_beqz", 64'(lat[1]), 64'd3);
    wait_ret(3); chk("li_pc", 64'(pc), 64'h15);
    wait_ret(4); chk("beqz_not_taken", 64'(pc), 64'h16);
    wait_ret(5); chk("jr_back_ff", 64'(pc), 64'hFF);
    wait_ret(6); chk("nop_wrap", 64'(pc), 64'h00);
    chk("lat_nop", 64'(lat[5]), 64'd3);
    ready = 1'b0;

    clear_mem();
    imem[0] = enc_i(4'h9, 3'd0, 8'hFF);
    do_reset(1'b1);
    wait_ret(1); chk("jr_m1_a", 64'(pc), 64'h00);
    wait_ret(2); chk("jr_m1_b", 64'(pc), 64'h00);
    ready = 1'b0;

    // pause during EXEC of ADD at 0x20
    clear_mem();
    imem[0]     = enc_i(4'h5, 3'd1, 8'h03);
    imem[1]     = enc_i(4'h5, 3'd2, 8'h04);
    imem[2]     = enc_i(4'h9, 3'd0, 8'h1D);
    imem[8'h20] = enc_r(4'h1, 3'd3, 3'd1, 3'd2);
    imem[8'h21] = 16'hF000;
    do_reset(1'b1);
    wait_ret(3);
    chk("pause_pc20", 64'(pc), 64'h20);
    @(negedge clk);
    @(negedge clk);
    ready = 1'b0;
    wait_ret(4);
    chk("pause_pc21", 64'(pc), 64'h21);
    chk_reg("pause_r3", 3, 64'd7);
    repeat (5) @(negedge clk);
    chk("pause_no_req", 64'(imem_req), 64'd0);
    chk("pause_retires", 64'(n_retire), 64'd4);
    chk("pause_pc_held", 64'(pc), 64'h21);
    ready = 1'b1;
    k = 0;
    while (!imem_req && k < 20) begin @(negedge clk); k++; end
    chk("resume_req", 64'(imem_req), 64'd1);
    chk("resume_addr", 64'(imem_addr), 64'h21);
    wait_halt();
    chk("resume_retires", 64'(n_retire), 64'd5);

    // illegal opcode B at pc 4
    clear_mem();
    imem[0] = enc_i(4'h5, 3'd1, 8'h05);
    imem[1] = 16'h0000; imem[2] = 16'h0000; imem[3] = 16'h0000;
    imem[4] = enc_r(4'hB, 3'd3, 3'd1, 3'd1);
    imem[5] = 16'h0000;
    imem[6] = 16'hF000;
    do_reset(1'b1);
    wait_ret(4);
    chk("ill_before", 64'(illegal), 64'd0);
    chk("ill_pc4", 64'(pc), 64'h4);
    wait_ret(5);
    chk("ill_set", 64'(illegal), 64'd1);
    chk("ill_pc5", 64'(pc), 64'h5);
    chk("lat_ill", 64'(lat[4]), 64'd3);
    wait_halt();
    chk("ill_sticky", 64'(illegal), 64'd1);
    chk_reg("ill_r3", 3, 64'd0);
    chk_reg("ill_r1", 1, 64'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_illegal", 64'(illegal), 64'd0);

    // reset in the middle of a stalled fetch
    clear_mem();
    imem[0] = enc_i(4'h5, 3'd7, 8'h7F);
    imem[1] = 16'h0000;
    iwait[1] = 100;
    do_reset(1'b1);
    k = 0;
    while (!(imem_req && pc == 8'h01) && k < 50) begin @(negedge clk); k++; end
    chk("fetch_stalled", 64'(imem_req), 64'd1);
    chk_reg("pre_rst_r7", 7, 64'h7F);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_imem_req", 64'(imem_req), 64'd0);
    chk("rst_pc", 64'(pc), 64'd0);
    chk("rst_retire", 64'(retire), 64'd0);
    chk("rst_dmem_req", 64'(dmem_req), 64'd0);
    chk("rst_dmem_we", 64'(dmem_we), 64'd0);
    ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int r = 0; r < 8; r++) chk_reg("rst_regs", r, 64'd0);
    repeat (5) @(negedge clk);
    chk("idle_no_req", 64'(imem_req), 64'd0);
    chk("idle_pc", 64'(pc), 64'd0);

    chk("handshake_total", 64'(hs_viol), 64'd0);
    chk("halt_req_total", 64'(halt_req), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/multicycle_core.md
Name: multicycle_core

Overview:
- Parametrised multi-cycle successor to the single-cycle processor.
- One FSM sequences fetch, decode, execute, memory and writeback over several clocks.
- Instruction and data memories sit outside the block behind req/ack handshakes, so slow memories stall the core cleanly.
- Adds pause/resume via ready, HALT, illegal-opcode detection and a debug register-read port.

Parameters:
- DATA_W, 16, register/ALU/data-memory word width; legal values 16 to 64.
- PC_W, 8, program counter and instruction address width; legal values 8 to 16.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ready  in  1  run enable.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address, equal to pc.
- imem_ack  in  1  fetch complete; imem_rdata is valid in the same cycle.
- imem_rdata  in  16  instruction word.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = store, 0 = load.
- dmem_addr  out  8  data address, taken from imm8.
- dmem_wdata  out  DATA_W  store data.
- dmem_ack  in  1  data access complete.
- dmem_rdata  in  DATA_W  load data, valid with dmem_ack.
- pc  out  PC_W  current PC.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  HALT executed; sticky.
- illegal  out  1  undefined opcode seen; sticky.
- dbg_sel  in  3  debug register select.
- dbg_data  out  DATA_W  combinational read of register dbg_sel.

Behaviour:
- Instruction fields: op=[15:12], rd=[11:9], rs=[8:6], rt=[5:3], imm8=[7:0].
- sext() sign-extends imm8 to DATA_W; for branch arithmetic imm8 is sign-extended to PC_W.
- Opcodes:
  - 0 NOP.
  - 1 ADD, 2 SUB, 3 AND, 4 OR: rd = rs op rt.
  - 5 LI: rd = sext(imm8).
  - 6 LD: rd = dmem[imm8].
  - 7 ST: dmem[imm8] = rd.
  - 8 BEQZ: if rd == 0, pc = pc+1+imm8, else pc = pc+1.
  - 9 JR: pc = pc+1+imm8.
  - F HALT.
  - A–E: illegal. Sets illegal, then executes as NOP.
- Register file: 8 x DATA_W, all registers writable. Written only in WB.
- Arithmetic: ADD/SUB wrap modulo 2^DATA_W. PC arithmetic wraps modulo 2^PC_W.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Transitions:
  - IDLE -> FETCH when ready=1.
  - FETCH: latch the instruction register on imem_ack, then -> DECODE.
  - DECODE -> EXEC.
  - EXEC:
    - LD/ST -> MEM.
    - NOP, BEQZ, JR, illegal: update pc, pulse retire, -> FETCH (or IDLE if ready=0).
    - HALT -> HALT.
    - ALU ops and LI -> WB.
  - MEM: on dmem_ack, ST -> retire; LD -> WB.
  - WB: write rd, pc = pc+1, pulse retire, -> FETCH, or IDLE if ready=0.
- Latency with ack in the first request cycle:
  - ALU/LI: 4 cycles.
  - LD: 5 cycles. ST: 4 cycles.
  - Branch/NOP/JR: 3 cycles.
- Handshake rules:
  - A req rises on state entry and holds until the ack cycle; it drops the cycle after ack.
  - Address, we and wdata stay stable while req=1.
  - An ack while req=0 is ignored.
  - An unbounded stall is legal.
- ready:
  - Sampled only at instruction boundaries.
  - Dropping ready mid-instruction lets the current instruction finish, then the core enters IDLE with pc pointing at the next instruction.
  - Raising ready again resumes from that pc.
- HALT: halted=1 and no further requests; left only by reset. retire pulses for HALT.
- Reset, asynchronous and effective immediately in any state, including mid-handshake:
  - pc = RESET_PC; state = IDLE; all registers = 0.
  - All req/we outputs = 0, retire = 0, halted = 0, illegal = 0.
  - dmem_addr = 0, dmem_wdata = 0.

Test Plan:
- Reset: assert rst_n=0 during FETCH with imem_req=1 -> imem_req falls without a clock edge; after release pc=RESET_PC, state IDLE, dbg_data=0 for all dbg_sel.
- Program, zero-wait memories:
  - Program: LI r1,5; LI r2,0xFD; ADD r3,r1,r2; ST r3,0x10; HALT.
  - Required: dbg r3=2; one store with dmem_addr=0x10, dmem_wdata=2; halted=1; 5 retire pulses; no req after HALT.
- Stall: imem_ack delayed 3 cycles and dmem_ack delayed 2 cycles on LD -> req held, addresses stable, no retire until ack; LD r4 gets dmem_rdata 0x1234.
- Branch: BEQZ r0,+3 at pc=0x10 -> pc=0x14. BEQZ r1(=5) -> pc=0x11. JR -1 at 0x00 -> pc=0x00. With PC_W=8, NOP at 0xFF -> pc=0x00.
- Pause: drop ready during EXEC of ADD at pc=0x20 -> ADD retires, IDLE, pc=0x21, no imem_req; raise ready -> fetch from 0x21.
- Illegal: opcode 0xB at pc=4 -> illegal=1 and sticky, retire pulses, pc=5, no register changes.
